// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bus between the instruction-cycle sequencer and its decoders/datapath
interface control_sequencer_if;
  logic [63:0] data_bus;
  logic [32:0] cw_dec;
  logic [63:0] k_dec;
  logic [4:0]  alu_status;
  logic        stall;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] cw;
  logic [63:0] K;
  logic        fetch;
  logic        fault;
  modport master (
    input  data_bus, cw_dec, k_dec, alu_status, stall,
    output I, state, status, cw, K, fetch, fault
  );
  modport slave (
    output data_bus, cw_dec, k_dec, alu_status, stall,
    input  I, state, status, cw, K, fetch, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute/halt instruction sequencer with watchdog fault; stall freeze enabled by CONTROL_SEQ_STALL_EN
module control_sequencer #(
  parameter int MAX_EXEC = 4
) (
  input logic clock,
  input logic reset,
  control_sequencer_if.master bus
);
  localparam logic [32:0] FETCH_CW = 33'h0_7DFF_FD10;
  localparam logic [32:0] NOP_CW   = 33'h0_7DFF_FC00;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} phase_t;
  phase_t phase, phase_nx;
  logic [31:0] i_nx;
  logic [1:0]  state_nx;
  logic [4:0]  status_nx, cnt, cnt_nx, cnt_inc;
  logic        fault_nx, hold;
`ifdef CONTROL_SEQ_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif
  assign cnt_inc = cnt + 5'd1;
  // control word and constant to the datapath, combinational from phase and decoder
  always_comb begin
    bus.cw    = (hold || phase == HALT) ? NOP_CW : (phase == FETCH) ? FETCH_CW : bus.cw_dec;
    bus.K     = (!hold && phase == EXEC) ? bus.k_dec : 64'd0;
    bus.fetch = phase == FETCH;
  end
  // next-state: fetch loads I, execute follows decoder next_state until 00 or watchdog trips
  always_comb begin
    phase_nx  = phase;
    i_nx      = bus.I;
    state_nx  = bus.state;
    status_nx = bus.status;
    cnt_nx    = cnt;
    fault_nx  = bus.fault;
    if (!hold && phase == FETCH) begin
      i_nx     = bus.data_bus[31:0];
      state_nx = 2'd0;
      cnt_nx   = 5'd0;
      phase_nx = EXEC;
    end else if (!hold && phase == EXEC) begin
      if (bus.cw_dec[2]) status_nx = bus.alu_status;
      if (bus.cw_dec[1:0] == 2'b00) phase_nx = FETCH;
      else begin
        state_nx = bus.cw_dec[1:0];
        cnt_nx   = cnt_inc;
        if (cnt_inc == 5'(MAX_EXEC)) begin
          fault_nx = 1'b1;
          phase_nx = HALT;
        end
      end
    end
  end
  // architectural registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase      <= FETCH;
      bus.I      <= 32'd0;
      bus.state  <= 2'd0;
      bus.status <= 5'd0;
      bus.fault  <= 1'b0;
      cnt        <= 5'd0;
    end else begin
      phase      <= phase_nx;
      bus.I      <= i_nx;
      bus.state  <= state_nx;
      bus.status <= status_nx;
      bus.fault  <= fault_nx;
      cnt        <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer
module tb_control_sequencer;
  localparam logic [32:0] FETCH_CW = 33'h0_7DFF_FD10;
  localparam logic [32:0] NOP_CW   = 33'h0_7DFF_FC00;
  localparam logic [32:0] CW_BASE  = 33'h1_ABCD_E000;
  typedef struct {
    string       tag;
    logic [32:0] cw;
    logic [63:0] k;
    logic        f;
    logic [31:0] i;
    logic [1:0]  st;
    logic [4:0]  sts;
    logic        flt;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  control_sequencer_if bus();
  control_sequencer #(.MAX_EXEC(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(input string tag, input logic [32:0] cw, input logic [63:0] k, input logic f,
                              input logic [31:0] i, input logic [1:0] st, input logic [4:0] sts, input logic flt);
    exp_t e;
    e.tag = tag; e.cw = cw; e.k = k; e.f = f; e.i = i; e.st = st; e.sts = sts; e.flt = flt;
    return e;
  endfunction
  function automatic logic [32:0] mkcw(input logic sld, input logic [1:0] ns);
    return {CW_BASE[32:3], sld, ns};
  endfunction
  task automatic score();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".cw"},     64'(bus.cw),     64'(e.cw));
    check({e.tag, ".K"},      bus.K,           e.k);
    check({e.tag, ".fetch"},  64'(bus.fetch),  64'(e.f));
    check({e.tag, ".I"},      64'(bus.I),      64'(e.i));
    check({e.tag, ".state"},  64'(bus.state),  64'(e.st));
    check({e.tag, ".status"}, 64'(bus.status), 64'(e.sts));
    check({e.tag, ".fault"},  64'(bus.fault),  64'(e.flt));
  endtask
  task automatic cyc(input logic [63:0] data, input logic [32:0] cwd, input logic [63:0] kd,
                     input logic [4:0] alu, input exp_t e);
    bus.data_bus = data;
    bus.cw_dec = cwd;
    bus.k_dec = kd;
    bus.alu_status = alu;
    sb.push_back(e);
    @(negedge clock);
    score();
    @(posedge clock);
    #1;
  endtask
  initial begin
    bus.stall = 1'b0;
    cyc(64'hFFFF_0000_1234_5678, mkcw(1'b1, 2'b01), 64'h1, 5'h1F,
        mk("reset", FETCH_CW, 64'd0, 1'b1, 32'd0, 2'd0, 5'd0, 1'b0));
    reset = 1'b1;
    cyc(64'hAAAA_BBBB_9400_0010, mkcw(1'b0, 2'b00), 64'h0123_4567_89AB_CDEF, 5'd0,
        mk("c0_fetch", FETCH_CW, 64'd0, 1'b1, 32'd0, 2'd0, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b00), 64'h0123_4567_89AB_CDEF, 5'd0,
        mk("c1_exec", mkcw(1'b0, 2'b00), 64'h0123_4567_89AB_CDEF, 1'b0, 32'h9400_0010, 2'd0, 5'd0, 1'b0));
    cyc(64'h0000_0000_B000_1234, mkcw(1'b0, 2'b01), 64'h5, 5'd0,
        mk("c2_fetch", FETCH_CW, 64'd0, 1'b1, 32'h9400_0010, 2'd0, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b01), 64'h11, 5'd0,
        mk("m0", mkcw(1'b0, 2'b01), 64'h11, 1'b0, 32'hB000_1234, 2'd0, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b10), 64'h22, 5'd0,
        mk("m1", mkcw(1'b0, 2'b10), 64'h22, 1'b0, 32'hB000_1234, 2'd1, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b1, 2'b00), 64'h33, 5'b10101,
        mk("m2", mkcw(1'b1, 2'b00), 64'h33, 1'b0, 32'hB000_1234, 2'd2, 5'd0, 1'b0));
    cyc(64'h0000_0000_1111_2222, mkcw(1'b1, 2'b00), 64'h44, 5'b00011,
        mk("sts_load", FETCH_CW, 64'd0, 1'b1, 32'hB000_1234, 2'd2, 5'b10101, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b00), 64'h55, 5'b00011,
        mk("sts_noload", mkcw(1'b0, 2'b00), 64'h55, 1'b0, 32'h1111_2222, 2'd0, 5'b10101, 1'b0));
    cyc(64'h0000_0000_DEAD_BEEF, mkcw(1'b0, 2'b01), 64'h66, 5'd0,
        mk("sts_hold", FETCH_CW, 64'd0, 1'b1, 32'h1111_2222, 2'd0, 5'b10101, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b01), 64'h77, 5'd0,
        mk("run0", mkcw(1'b0, 2'b01), 64'h77, 1'b0, 32'hDEAD_BEEF, 2'd0, 5'b10101, 1'b0));
    for (int n = 1; n < 4; n++)
      cyc(64'h0, mkcw(1'b0, 2'b01), 64'h77, 5'd0,
          mk($sformatf("run%0d", n), mkcw(1'b0, 2'b01), 64'h77, 1'b0, 32'hDEAD_BEEF, 2'd1, 5'b10101, 1'b0));
    cyc(64'h0000_0000_0BAD_0BAD, mkcw(1'b1, 2'b00), 64'h88, 5'b11111,
        mk("halt0", NOP_CW, 64'd0, 1'b0, 32'hDEAD_BEEF, 2'd1, 5'b10101, 1'b1));
    cyc(64'h0, mkcw(1'b0, 2'b00), 64'h99, 5'd0,
        mk("halt1", NOP_CW, 64'd0, 1'b0, 32'hDEAD_BEEF, 2'd1, 5'b10101, 1'b1));
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk("rst_halt", FETCH_CW, 64'd0, 1'b1, 32'd0, 2'd0, 5'd0, 1'b0));
    score();
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(64'h0000_0000_0000_0042, mkcw(1'b0, 2'b01), 64'hAB, 5'd0,
        mk("f_again", FETCH_CW, 64'd0, 1'b1, 32'd0, 2'd0, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b1, 2'b01), 64'hAB, 5'b01010,
        mk("e_again", mkcw(1'b1, 2'b01), 64'hAB, 1'b0, 32'h42, 2'd0, 5'd0, 1'b0));
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk("rst_exec", FETCH_CW, 64'd0, 1'b1, 32'd0, 2'd0, 5'd0, 1'b0));
    score();
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(64'h0000_0000_9400_0010, mkcw(1'b0, 2'b00), 64'hCD, 5'd0,
        mk("f_post", FETCH_CW, 64'd0, 1'b1, 32'd0, 2'd0, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b00), 64'hCD, 5'd0,
        mk("e_post", mkcw(1'b0, 2'b00), 64'hCD, 1'b0, 32'h9400_0010, 2'd0, 5'd0, 1'b0));
`ifdef CONTROL_SEQ_STALL_EN
    bus.stall = 1'b1;
    for (int n = 0; n < 3; n++)
      cyc(64'h0000_0000_5555_AAAA, mkcw(1'b0, 2'b00), 64'hEE, 5'd0,
          mk($sformatf("stall%0d", n), NOP_CW, 64'd0, 1'b1, 32'h9400_0010, 2'd0, 5'd0, 1'b0));
    bus.stall = 1'b0;
    cyc(64'h0000_0000_5555_AAAA, mkcw(1'b0, 2'b00), 64'hEE, 5'd0,
        mk("unstall", FETCH_CW, 64'd0, 1'b1, 32'h9400_0010, 2'd0, 5'd0, 1'b0));
    cyc(64'h0, mkcw(1'b0, 2'b00), 64'hEE, 5'd0,
        mk("stall_exec", mkcw(1'b0, 2'b00), 64'hEE, 1'b0, 32'h5555_AAAA, 2'd0, 5'd0, 1'b0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction-cycle sequencer of the control unit, sitting directly upstream of the per-opcode instruction decoders and downstream of their outputs. Runs a fetch phase that drives its own fetch control word and captures the instruction from the data bus into the instruction register. It then presents `I`, `state` and `status` to the decoders and forwards the selected decoder's 33-bit control word and `K` to the datapath for one or more execute cycles. It also owns the status register, applies the decoder's `next_state`, and guards against runaway multi-cycle instructions.

## Interface
- `MAX_EXEC`, default 4: execute cycles allowed per instruction before fault (2..16).
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data_bus`  input  64  datapath data bus; bits [31:0] hold the fetched instruction during fetch.
- `cw_dec`  input  33  control word from the opcode-selected decoder.
- `k_dec`  input  64  constant from the opcode-selected decoder.
- `alu_status`  input  5  ALU flags, loaded when the control word's status_ld bit is set.
- `stall`  input  1  freeze request (only with CONTROL_SEQ_STALL_EN).
- `I`  output  32  instruction register.
- `state`  output  2  execute-state index presented to the decoders.
- `status`  output  5  status register.
- `cw`  output  33  control word to the datapath.
- `K`  output  64  constant to the datapath.
- `fetch`  output  1  high during the fetch phase.
- `fault`  output  1  sticky watchdog fault.

## Operation
- Control word layout, MSB first:
  - [32] alu_en, [31] alu_bs, [30:26] alu_fs, [25] rf_b_en.
  - [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da.
  - [9] rf_w, [8] ram_en, [7] ram_w, [6] pc_en, [5:4] pc_fs, [3] pc_is, [2] status_ld, [1:0] next_state.
- FETCH_CW = 33'h0_7DFF_FD10: ALU off, fs 11111, regs 31, ram_en=1, pc_fs=01 (PC+4), no writes.
- NOP_CW = 33'h0_7DFF_FC00: FETCH_CW with ram_en=0 and pc_fs=00 (hold).
- Phases are FETCH, EXEC and HALT.
  - FETCH:
    - cw=FETCH_CW, K=0, fetch=1.
    - At the edge: I<=data_bus[31:0], state<=0, exec_cnt<=0, go to EXEC.
  - EXEC:
    - cw=cw_dec, K=k_dec.
    - At the edge, if cw_dec[2]: status<=alu_status.
    - If cw_dec[1:0]==00: go to FETCH.
    - Else: state<=cw_dec[1:0], exec_cnt+1.
    - If exec_cnt+1==MAX_EXEC and next_state≠00: fault<=1, go to HALT.
  - HALT:
    - cw=NOP_CW, K=0. I, state and status are held.
    - Left only by reset.
- The status load and the return to FETCH in the same edge both take effect.
- `state` and `I` change only at edges, never combinationally.

## Timing
- Reset values: I=0, state=0, status=0, fault=0, phase FETCH (so cw=FETCH_CW, K=0, fetch=1).
- Reset asserted mid-instruction aborts immediately.
- Instruction latency is 1 fetch cycle + N execute cycles, where N is the number of decoder cycles until next_state==00. A single-cycle instruction takes 2 cycles.
- `cw`/`K` are combinational from phase, cw_dec, k_dec and stall. The decoder path settles in the same cycle; no pipelining.
- `I` is valid from the first EXEC cycle. `status` reflects a load from the cycle after status_ld.
- The exec counter is 5 bits and never wraps: fault triggers before overflow.

## Configuration
- `CONTROL_SEQ_STALL_EN` defined:
  - While stall=1: cw=NOP_CW, K=0, and no register updates (I, state, status, phase and exec_cnt all hold).
  - Stall cycles do not count toward MAX_EXEC.
  - When stall deasserts, the interrupted phase resumes with the same state.
- Not defined: the `stall` port is present but ignored, and its logic is removed.

## Test plan
- Reset release, data_bus[31:0]=32'h9400_0010, cw_dec next_state=00:
  - Cycle 0: cw=FETCH_CW.
  - Cycle 1: I=32'h9400_0010, cw=cw_dec.
  - Cycle 2: back to FETCH.
- Three-cycle instruction: cw_dec next_state sequence 01, 10, 00 -> state presents 0, 1, 2 across EXEC cycles, then FETCH; fault stays 0.
- status_ld=1 with alu_status=5'b10101 in the final EXEC cycle -> status=5'b10101 in the following FETCH cycle; status unchanged when status_ld=0.
- Runaway instruction, cw_dec next_state held at 01 with MAX_EXEC=4:
  - fault=1 after the 4th EXEC edge; cw=NOP_CW thereafter.
  - Reset clears fault and returns to FETCH.
- Async reset asserted mid-EXEC (between edges) -> outputs immediately take their reset values and FETCH_CW.
- With CONTROL_SEQ_STALL_EN, stall=1 for 3 cycles during FETCH:
  - cw=NOP_CW and I is unchanged throughout.
  - On release, FETCH repeats and loads the instruction.
